// File: rtl/wave_pkg.sv
// wave_pkg: shared encodings and default widths for the wave_shaper slice.
// Holds wave_sel codes, FSM state encoding and default ACC_W/OUT_W.
package wave_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int OUT_W_DEF = 8;

  typedef enum logic [1:0] {
    WAVE_OFF    = 2'b00,
    WAVE_SQUARE = 2'b01,
    WAVE_SAW    = 2'b10,
    WAVE_TRI    = 2'b11
  } wave_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/wave_lut.sv
// wave_lut: combinational phase-to-sample map for square/saw/triangle.
// Ports: p (top 8 phase bits), sel (waveform), val (8-bit unsigned sample).
module wave_lut
  import wave_pkg::*;
(
  input  logic [7:0] p,
  input  wave_t      sel,
  output logic [7:0] val
);

  logic [7:0] dbl;

  assign dbl = {p[6:0], 1'b0};

  always_comb begin
    val = '0;
    unique case (1'b1)
      sel == WAVE_SQUARE: val = {8{p[7]}};
      sel == WAVE_SAW:    val = p;
      sel == WAVE_TRI:    val = p[7] ? ~dbl : dbl;
      default:            val = '0;
    endcase
  end

endmodule

// File: rtl/wave_shaper.sv
// wave_shaper: strobe-driven tone generator with shadowed note handshake.
// Ports: clk, n_rst (async low), divide_now strobe, freq_inc/wave_sel/
// note_valid/note_ready note channel, sample/sample_valid output.
// Macro WAVE_PHASE_RESET_EN: restart phase at zero when a note applies.
module wave_shaper
  import wave_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             divide_now,
  input  logic [ACC_W-1:0] freq_inc,
  input  logic [1:0]       wave_sel,
  input  logic             note_valid,
  output logic             note_ready,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid
);

  state_t           state;
  state_t           st_nxt;
  wave_t            act_sel;
  wave_t            sh_sel;
  wave_t            eff_sel;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] act_inc;
  logic [ACC_W-1:0] sh_inc;
  logic [ACC_W-1:0] eff_inc;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] acc_nxt;
  logic             pending;
  logic             accept;
  logic             apply;
  logic [7:0]       p;
  logic [7:0]       lut_val;

  assign note_ready = !pending;
  assign accept     = note_valid && !pending;
  assign apply      = divide_now && pending;

  // Strobe sees the shadow note if one is waiting.
  assign eff_inc = apply ? sh_inc : act_inc;
  assign eff_sel = apply ? sh_sel : act_sel;

  assign st_nxt = (eff_sel == WAVE_OFF) ?
                  ST_IDLE : ST_RUN;

`ifdef WAVE_PHASE_RESET_EN
  assign base = apply ? '0 : acc;
`else
  assign base = acc;
`endif

  assign acc_nxt = (st_nxt == ST_RUN) ?
                   base + eff_inc : '0;

  assign p = acc_nxt[ACC_W-1 -: 8];

  wave_lut u_lut (
    .p   (p),
    .sel (eff_sel),
    .val (lut_val)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      acc          <= '0;
      act_inc      <= '0;
      act_sel      <= WAVE_OFF;
      sh_inc       <= '0;
      sh_sel       <= WAVE_OFF;
      pending      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= divide_now;
      if (accept) begin
        sh_inc  <= freq_inc;
        sh_sel  <= wave_t'(wave_sel);
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
      if (divide_now) begin
        act_inc <= eff_inc;
        act_sel <= eff_sel;
        state   <= st_nxt;
        acc     <= acc_nxt;
        sample  <= lut_val;
      end
    end
  end

endmodule

// File: tb/tb_wave_shaper.sv
// tb_wave_shaper: randomized + directed bench with scoreboard for wave_shaper.
// Driver pushes model predictions; a negedge monitor pops and compares.
module tb_wave_shaper;

  localparam int ACC_W = 16;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             divide_now = 1'b0;
  logic             note_valid = 1'b0;
  logic [ACC_W-1:0] freq_inc = '0;
  logic [1:0]       wave_sel = '0;
  logic             note_ready;
  logic [OUT_W-1:0] sample;
  logic             sample_valid;

  int compared = 0;
  int mismatched = 0;
  int exp_q[$];

  // Reference model state: phase as a plain integer, notes as ints.
  longint m_acc;
  longint m_inc;
  int     m_sel;
  bit     m_pend;
  longint s_inc;
  int     s_sel;

  always #5 clk = ~clk;

  wave_shaper dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .divide_now   (divide_now),
    .freq_inc     (freq_inc),
    .wave_sel     (wave_sel),
    .note_valid   (note_valid),
    .note_ready   (note_ready),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  function automatic int shape(input int sel, input int p);
    case (sel)
      1: return (p >= 128) ? 255 : 0;
      2: return p;
      3: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input int act,
                       input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic mreset();
    m_acc = 0; m_inc = 0; m_sel = 0;
    m_pend = 0; s_inc = 0; s_sel = 0;
  endtask

  task automatic model(input bit dn, input bit nv, input int inc,
                       input int sel, output bit acc_ok,
                       output int e);
    bit     was_pend;
    bit     applied;
    longint base;
    was_pend = m_pend;
    applied = 0;
    e = -1;
    if (dn) begin
      if (m_pend) begin
        m_inc = s_inc; m_sel = s_sel;
        m_pend = 0; applied = 1;
      end
      base = m_acc;
`ifdef WAVE_PHASE_RESET_EN
      if (applied) base = 0;
`endif
      if (m_sel == 0) m_acc = 0;
      else m_acc = (base + m_inc) % (longint'(1) << ACC_W);
      e = shape(m_sel, int'(m_acc >> (ACC_W - 8)));
    end
    acc_ok = nv && !was_pend;
    if (acc_ok) begin
      s_inc = inc; s_sel = sel; m_pend = 1;
    end
  endtask

  task automatic cycle(input bit dn, input bit nv, input int inc,
                       input int sel, output bit acc_ok);
    int e;
    check("note_ready", int'(note_ready), int'(!m_pend));
    divide_now = dn;
    note_valid = nv;
    freq_inc = inc[ACC_W-1:0];
    wave_sel = sel[1:0];
    model(dn, nv, inc, sel, acc_ok, e);
    @(posedge clk);
    #1;
    if (dn) exp_q.push_back(e);
    divide_now = 1'b0;
    note_valid = 1'b0;
  endtask

  task automatic strobe();
    bit ok;
    cycle(1'b1, 1'b0, 0, 0, ok);
  endtask

  task automatic idle();
    bit ok;
    cycle(1'b0, 1'b0, 0, 0, ok);
  endtask

  task automatic offer(input int inc, input int sel);
    bit ok;
    int n;
    n = 0;
    do begin
      cycle(1'b0, 1'b1, inc, sel, ok);
      n++;
    end while (!ok && n < 8);
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL offer_timeout: got no accept, want accept");
    end
  endtask

  task automatic rst_check(input string tag);
    check({tag, "_sample"}, int'(sample), 0);
    check({tag, "_valid"}, int'(sample_valid), 0);
    check({tag, "_ready"}, int'(note_ready), 1);
  endtask

  always @(negedge clk) begin
    if (n_rst) begin
      if (sample_valid) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL spurious_valid: got 1, want 0");
        end else begin
          check("sample", int'(sample), exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        compared++; mismatched++;
        $display("FAIL missing_valid: got 0, want 1");
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit offering;
    bit dn;
    int r_inc;
    int r_sel;
    mreset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_check("reset");
    n_rst = 1'b1;

    strobe();
    idle();

    // Saw sweep with wrap.
    offer(32'h0100, 2);
    repeat (257) strobe();

    // Collision: accept during strobe, held note while pending.
    cycle(1'b1, 1'b1, 32'h0200, 2, ok);
    cycle(1'b0, 1'b1, 32'h0300, 3, ok);
    cycle(1'b1, 1'b1, 32'h0300, 3, ok);
    offer(32'h0300, 3);
    repeat (2) strobe();

    // Triangle sweep.
    offer(32'h0100, 3);
    repeat (256) strobe();

    // Square sweep with gaps between strobes.
    offer(32'h0100, 1);
    repeat (256) begin
      strobe();
      idle();
    end

    // Note off.
    offer(0, 0);
    repeat (3) strobe();

    // Phase continuity / restart on note change.
    offer(32'h4000, 2);
    strobe();
    offer(32'h0100, 2);
    repeat (2) strobe();

    // Zero increment holds phase.
    offer(0, 2);
    repeat (4) strobe();

    // Mid-run asynchronous reset.
    offer(32'h0123, 2);
    repeat (5) strobe();
    n_rst = 1'b0;
    #1;
    rst_check("midrst");
    exp_q.delete();
    mreset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    strobe();
    idle();

    // Randomized traffic with a producer that holds notes.
    offering = 0;
    r_inc = 0;
    r_sel = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!offering && $urandom_range(0, 3) == 0) begin
        offering = 1;
        r_sel = int'($urandom_range(0, 3));
        if ($urandom_range(0, 4) == 0) r_inc = 0;
        else r_inc = int'($urandom_range(0, (1 << ACC_W) - 1));
      end
      dn = ($urandom_range(0, 2) != 0);
      cycle(dn, offering, r_inc, r_sel, ok);
      if (ok) offering = 0;
    end

    repeat (3) idle();
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wave_shaper.md
# wave_shaper

Sample-domain tone generator that sits directly downstream of the sample-rate divider: on each one-cycle `divide_now` strobe it advances a phase accumulator and emits one registered 8-bit sample of the selected waveform (square, saw, triangle) to the output stage. New notes (frequency increment plus waveform) arrive through a valid/ready handshake. A note is held in a shadow register and applied only on a sample strobe, so the output never glitches mid-sample.

## Interface
- `ACC_W`, 16: phase accumulator and `freq_inc` width; must be ≥ 8.
- `OUT_W`, 8: sample width; fixed at 8 in this revision.
- `clk` in 1: system clock; one clock domain.
- `n_rst` in 1: reset, asynchronous and active-low.
- `divide_now` in 1: one-cycle sample strobe from the sample-rate divider.
- `freq_inc` in ACC_W: phase increment per sample for the offered note.
- `wave_sel` in 2: waveform for the offered note. 00 = off, 01 = square, 10 = saw, 11 = triangle.
- `note_valid` in 1: a note is offered on `freq_inc`/`wave_sel`.
- `note_ready` out 1: the block can accept a note.
- `sample` out OUT_W: current sample, unsigned.
- `sample_valid` out 1: one-cycle pulse, high when `sample` has just updated.

## Operation
- **States:**
  - IDLE: no active note.
  - RUN: active note with `wave_sel` ≠ 00.
- **Note acceptance:**
  - A note is accepted when `note_valid && note_ready`.
  - On acceptance, `freq_inc` and `wave_sel` are latched into the shadow register and `pending` is set.
  - `note_ready = !pending`.
- **Note application:** on the next `divide_now` with `pending` set:
  - The shadow values become active and `pending` clears.
  - Next state is RUN if the shadow `wave_sel` ≠ 00, else IDLE.
- **Sample step:** on every `divide_now`, using the active settings after any application:
  - RUN: `acc_next = acc + inc`, mod 2^ACC_W (natural wrap, no saturation).
  - IDLE: `acc_next = 0`.
- **Waveform mapping:** let p = `acc_next[ACC_W-1 -: 8]`.
  - Square: `p[7] ? 255 : 0`.
  - Saw: `p`.
  - Triangle: `p[7] ? ~{p[6:0],0} : {p[6:0],0}`.
  - IDLE: 0.
- `sample_valid` pulses on every `divide_now`, including in IDLE, so downstream is always fed.
- `freq_inc` = 0 in RUN: the accumulator holds and the sample stays constant; `sample_valid` still pulses.

## Timing
- **Reset values:** `sample` = 0, `sample_valid` = 0, `note_ready` = 1, `acc` = 0, `pending` = 0, state IDLE, active inc = 0, active `wave_sel` = 00.
- **Latency:** `divide_now` high in cycle N → `acc`, `sample` and state update at the end of cycle N; `sample_valid` = 1 during cycle N+1 only.
- **Application timing:** a pending note applied by the strobe in cycle N already affects the sample that becomes valid in N+1. `note_ready` returns high in N+1.
- **Simultaneous `note_valid` and `divide_now`, no pending note:**
  - The note is accepted.
  - The current strobe still uses the old active settings.
  - The new note applies at the following strobe.
- **`note_valid` while pending:** the note is not accepted. The producer holds it until `note_ready` returns high.
- **Back-to-back strobes** (one every cycle) are legal; one sample is produced per strobe.
- **`n_rst` asserted mid-operation:** everything returns to reset values immediately; a pending note is discarded.

## Configuration
- Macro: `WAVE_PHASE_RESET_EN`.
- Defined: when a pending note is applied, the accumulator restarts, so `acc_next = 0 + inc`. Every new note starts at phase zero.
- Undefined: phase is continuous across note changes, `acc_next = acc + inc` with the new inc.
- IDLE always clears `acc` regardless of the macro.

## Structure
- Shared package `wave_pkg` holds:
  - the `wave_sel` encodings (WAVE_OFF, WAVE_SQUARE, WAVE_SAW, WAVE_TRI);
  - the state encoding (ST_IDLE, ST_RUN);
  - the default ACC_W/OUT_W constants.
- One sub-module, `wave_lut`: purely combinational mapping of (p, `wave_sel`) → sample. It is instantiated once on `acc_next`.
- The top level holds the FSM, the shadow/pending handshake, the accumulator and the output registers.

## Test plan
- **Reset:** assert `n_rst` low for 3 cycles → `sample` = 0, `sample_valid` = 0, `note_ready` = 1. Strobe `divide_now` → `sample_valid` pulses with `sample` = 0.
- **Saw:** accept inc = 0x0100, saw, then 257 strobes.
  - The first strobe applies the note: p = 1, `sample` = 1.
  - Subsequent samples are 2, 3, …, 255, 0, 1 (wrap).
  - `sample_valid` is exactly one cycle after each strobe.
- **Triangle / square:** inc = 0x0100.
  - Triangle gives p = 1 → 2 and p = 128 → 255.
  - Square gives 0 for p = 1..127 and 255 for p = 128..255.
- **Handshake collision:** `note_valid` in the same cycle as `divide_now` with a saw note active (inc 0x0100) and a new note inc 0x0200 offered.
  - That strobe still uses inc 0x0100.
  - `note_ready` is low until the next strobe, which steps by 0x0200.
  - A second `note_valid` held during pending is not accepted until `note_ready` returns.
- **Note off:** accept `wave_sel` = 00 while running → at the next strobe the state is IDLE, `sample` = 0 and `acc` = 0.
- **Phase reset / mid-run reset:**
  - At `acc` = 0x4000, apply a new note with inc 0x0100 → with `WAVE_PHASE_RESET_EN`, `acc` = 0x0100; without it, `acc` = 0x4100.
  - Pulse `n_rst` low mid-run → all outputs return to reset values immediately.
